// File: rtl/rf_write_arbiter_pkg.sv
// Shared widths, the %g0 address and the grant encoding for the register-file
// write arbiter and its pending-load scoreboard.
package rf_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] G0_ADDR = '0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LD  = 1'b1
  } req_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the ALU/load write handshakes, register-file write port, scoreboard
// set, issue read selects and bypass outputs; slave is the arbiter side.
interface rf_write_arbiter_if;
  import rf_pkg::*;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              rf_ld;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              sb_set_valid;
  logic [ADDR_W-1:0] sb_set_addr;
  logic [ADDR_W-1:0] rd_a_addr;
  logic [ADDR_W-1:0] rd_b_addr;
  logic              rd_stall;
  logic              byp_a_hit;
  logic              byp_b_hit;
  logic [DATA_W-1:0] byp_data;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  ld_valid, ld_addr, ld_data,
    input  sb_set_valid, sb_set_addr, rd_a_addr, rd_b_addr,
    output alu_ready, ld_ready, rf_ld, rf_addr, rf_data,
    output rd_stall, byp_a_hit, byp_b_hit, byp_data
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output ld_valid, ld_addr, ld_data,
    output sb_set_valid, sb_set_addr, rd_a_addr, rd_b_addr,
    input  alu_ready, ld_ready, rf_ld, rf_addr, rf_data,
    input  rd_stall, byp_a_hit, byp_b_hit, byp_data
  );

endinterface

// File: rtl/rf_write_arbiter_scoreboard.sv
// Pending-load scoreboard: one bit per register, set by issue, cleared by the
// accepted load write; a same-edge set on the same register wins.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_valid_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_valid_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rd_a_addr_i,
  input  logic [ADDR_W-1:0] rd_b_addr_i,
  output logic              hit_a_o,
  output logic              hit_b_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_valid_i) pending_d[clr_addr_i] = 1'b0;
    if (set_valid_i && (set_addr_i != G0_ADDR)) pending_d[set_addr_i] = 1'b1;
    pending_d[G0_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign hit_a_o = pending_q[rd_a_addr_i] & (rd_a_addr_i != G0_ADDR);
  assign hit_b_o = pending_q[rd_b_addr_i] & (rd_b_addr_i != G0_ADDR);

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load
// unit, with a registered output stage; `RF_BYPASS_EN forwards that stage to issue.
module rf_write_arbiter
  import rf_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  rf_write_arbiter_if.slave  bus
);

  req_e              last_grant_q, last_grant_d;
  logic              rf_ld_q, rf_ld_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic              alu_ready;
  logic              ld_ready;
  logic              accept;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              sb_hit_a;
  logic              sb_hit_b;
  logic              out_hit_a;
  logic              out_hit_b;

  // Under contention the requester that did not win last time gets the port.
  assign alu_ready = bus.alu_valid & (~bus.ld_valid | (last_grant_q == REQ_LD));
  assign ld_ready  = bus.ld_valid  & (~bus.alu_valid | (last_grant_q == REQ_ALU));
  assign accept    = alu_ready | ld_ready;
  assign win_addr  = ld_ready ? bus.ld_addr : bus.alu_addr;
  assign win_data  = ld_ready ? bus.ld_data : bus.alu_data;

  always_comb begin
    last_grant_d = last_grant_q;
    rf_ld_d      = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;
    if (accept) begin
      last_grant_d = ld_ready ? REQ_LD : REQ_ALU;
      rf_addr_d    = win_addr;
      rf_data_d    = win_data;
      rf_ld_d      = (win_addr != G0_ADDR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= REQ_LD;
      rf_ld_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_ld_q      <= rf_ld_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
    end
  end

  rf_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_valid_i (bus.sb_set_valid),
    .set_addr_i  (bus.sb_set_addr),
    .clr_valid_i (ld_ready),
    .clr_addr_i  (bus.ld_addr),
    .rd_a_addr_i (bus.rd_a_addr),
    .rd_b_addr_i (bus.rd_b_addr),
    .hit_a_o     (sb_hit_a),
    .hit_b_o     (sb_hit_b)
  );

  assign out_hit_a = rf_ld_q & (rf_addr_q == bus.rd_a_addr) & (bus.rd_a_addr != G0_ADDR);
  assign out_hit_b = rf_ld_q & (rf_addr_q == bus.rd_b_addr) & (bus.rd_b_addr != G0_ADDR);

  assign bus.alu_ready = alu_ready;
  assign bus.ld_ready  = ld_ready;
  assign bus.rf_ld     = rf_ld_q;
  assign bus.rf_addr   = rf_addr_q;
  assign bus.rf_data   = rf_data_q;

`ifdef RF_BYPASS_EN
  assign bus.rd_stall  = sb_hit_a | sb_hit_b;
  assign bus.byp_a_hit = out_hit_a;
  assign bus.byp_b_hit = out_hit_b;
  assign bus.byp_data  = rf_data_q;
`else
  assign bus.rd_stall  = sb_hit_a | sb_hit_b | out_hit_a | out_hit_b;
  assign bus.byp_a_hit = 1'b0;
  assign bus.byp_b_hit = 1'b0;
  assign bus.byp_data  = '0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: handshakes, round-robin, %g0, scoreboard
// and async reset; expectations follow RF_BYPASS_EN when it is defined.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  logic clk;
  logic rst_n;
  int   nCompared;
  int   nMismatched;

  rf_write_arbiter_if bus ();

  rf_write_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idleInputs();
    bus.alu_valid    = 1'b0;
    bus.alu_addr     = '0;
    bus.alu_data     = '0;
    bus.ld_valid     = 1'b0;
    bus.ld_addr      = '0;
    bus.ld_data      = '0;
    bus.sb_set_valid = 1'b0;
    bus.sb_set_addr  = '0;
    bus.rd_a_addr    = '0;
    bus.rd_b_addr    = '0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idleInputs();
    bus.rd_a_addr = 5'd7;
    bus.rd_b_addr = 5'd9;
    #12;
    nCompared++;
    if (bus.rf_ld !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL reset_rf_ld got %0b want 0", bus.rf_ld);
    end
    nCompared++;
    if (bus.rf_addr !== 5'd0 || bus.rf_data !== 32'd0) begin
      nMismatched++; $display("[TB] FAIL reset_rf_bus got %0d/%h want 0/0", bus.rf_addr, bus.rf_data);
    end
    nCompared++;
    if (bus.rd_stall !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL reset_stall got %0b want 0", bus.rd_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idleInputs();
    nextCycle();
  endtask

  task automatic test_contention();
    logic expAlu;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd3;
    bus.ld_valid  = 1'b1;
    bus.ld_addr   = 5'd4;
    for (int i = 0; i < 4; i++) begin
      expAlu = ((i % 2) == 0);
      bus.alu_data = 32'hA000_0000 + i;
      bus.ld_data  = 32'hB000_0000 + i;
      #1;
      nCompared++;
      if (bus.alu_ready !== expAlu || bus.ld_ready !== !expAlu) begin
        nMismatched++;
        $display("[TB] FAIL rr_grant%0d got alu=%0b ld=%0b want alu=%0b ld=%0b",
                 i, bus.alu_ready, bus.ld_ready, expAlu, !expAlu);
      end
      nextCycle();
      nCompared++;
      if (bus.rf_ld !== 1'b1 || bus.rf_addr !== (expAlu ? 5'd3 : 5'd4) ||
          bus.rf_data !== (expAlu ? 32'hA000_0000 + i : 32'hB000_0000 + i)) begin
        nMismatched++;
        $display("[TB] FAIL rr_write%0d got ld=%0b addr=%0d data=%h want ld=1 addr=%0d",
                 i, bus.rf_ld, bus.rf_addr, bus.rf_data, expAlu ? 3 : 4);
      end
    end
    idleInputs();
    nextCycle();
    nCompared++;
    if (bus.rf_ld !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL rr_drain got rf_ld=%0b want 0", bus.rf_ld);
    end
  endtask

  task automatic test_single_alu();
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd5;
    bus.alu_data  = 32'hDEAD_BEEF;
    #1;
    nCompared++;
    if (bus.alu_ready !== 1'b1 || bus.ld_ready !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL alu_ready got %0b/%0b want 1/0", bus.alu_ready, bus.ld_ready);
    end
    nextCycle();
    idleInputs();
    nCompared++;
    if (bus.rf_ld !== 1'b1 || bus.rf_addr !== 5'd5 || bus.rf_data !== 32'hDEAD_BEEF) begin
      nMismatched++;
      $display("[TB] FAIL alu_write got ld=%0b addr=%0d data=%h want 1/5/deadbeef",
               bus.rf_ld, bus.rf_addr, bus.rf_data);
    end
    nextCycle();
    nCompared++;
    if (bus.rf_ld !== 1'b0 || bus.rf_addr !== 5'd5 || bus.rf_data !== 32'hDEAD_BEEF) begin
      nMismatched++;
      $display("[TB] FAIL alu_hold got ld=%0b addr=%0d data=%h want 0/5/deadbeef",
               bus.rf_ld, bus.rf_addr, bus.rf_data);
    end
  endtask

  task automatic test_g0();
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd0;
    bus.alu_data  = 32'h0000_1234;
    #1;
    nCompared++;
    if (bus.alu_ready !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL g0_ready got %0b want 1", bus.alu_ready);
    end
    nextCycle();
    nCompared++;
    if (bus.rf_ld !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL g0_no_write got rf_ld=%0b want 0", bus.rf_ld);
    end
    // ALU just won (on %g0), so contention now goes to the load unit.
    bus.alu_addr = 5'd2;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 5'd6;
    #1;
    nCompared++;
    if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL g0_grant got alu=%0b ld=%0b want 0/1", bus.alu_ready, bus.ld_ready);
    end
    nextCycle();
    idleInputs();
    bus.sb_set_valid = 1'b1;
    bus.sb_set_addr  = 5'd0;
    nextCycle();
    idleInputs();
    nextCycle();
    #1;
    nCompared++;
    if (bus.rd_stall !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL g0_stall got %0b want 0", bus.rd_stall);
    end
  endtask

  task automatic test_scoreboard();
    logic expStall;
    logic expHit;
    logic [31:0] expByp;
    bus.sb_set_valid = 1'b1;
    bus.sb_set_addr  = 5'd7;
    nextCycle();
    idleInputs();
    bus.rd_b_addr = 5'd7;
    #1;
    nCompared++;
    if (bus.rd_stall !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL sb_pending got stall=%0b want 1", bus.rd_stall);
    end
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 5'd7;
    bus.ld_data  = 32'h0000_0077;
    #1;
    nCompared++;
    if (bus.ld_ready !== 1'b1 || bus.rd_stall !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL sb_ld_accept got ready=%0b stall=%0b want 1/1", bus.ld_ready, bus.rd_stall);
    end
    nextCycle();
    bus.ld_valid = 1'b0;
    #1;
`ifdef RF_BYPASS_EN
    expStall = 1'b0; expHit = 1'b1; expByp = 32'h0000_0077;
`else
    expStall = 1'b1; expHit = 1'b0; expByp = 32'h0;
`endif
    nCompared++;
    if (bus.rd_stall !== expStall || bus.byp_b_hit !== expHit || bus.byp_data !== expByp ||
        bus.byp_a_hit !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL sb_out_stage got stall=%0b hitb=%0b hita=%0b byp=%h want %0b/%0b/0/%h",
               bus.rd_stall, bus.byp_b_hit, bus.byp_a_hit, bus.byp_data, expStall, expHit, expByp);
    end
    nextCycle();
    nCompared++;
    if (bus.rd_stall !== 1'b0 || bus.byp_b_hit !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL sb_cleared got stall=%0b hitb=%0b want 0/0", bus.rd_stall, bus.byp_b_hit);
    end
    idleInputs();
  endtask

  task automatic test_same_edge();
    bus.sb_set_valid = 1'b1;
    bus.sb_set_addr  = 5'd9;
    bus.ld_valid     = 1'b1;
    bus.ld_addr      = 5'd9;
    bus.ld_data      = 32'h0000_0099;
    nextCycle();
    idleInputs();
    nextCycle();
    bus.rd_a_addr = 5'd9;
    #1;
    nCompared++;
    if (bus.rf_ld !== 1'b0 || bus.rd_stall !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL set_wins got rf_ld=%0b stall=%0b want 0/1", bus.rf_ld, bus.rd_stall);
    end
    bus.rd_a_addr = 5'd10;
    #1;
    nCompared++;
    if (bus.rd_stall !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL set_wins_other got stall=%0b want 0", bus.rd_stall);
    end
    idleInputs();
  endtask

  task automatic test_async_reset();
    nextCycle();
    bus.sb_set_valid = 1'b1;
    bus.sb_set_addr  = 5'd12;
    bus.ld_valid     = 1'b1;
    bus.ld_addr      = 5'd13;
    bus.ld_data      = 32'h1313_1313;
    nextCycle();
    idleInputs();
    bus.rd_a_addr = 5'd12;
    #1;
    nCompared++;
    if (bus.rf_ld !== 1'b1 || bus.rd_stall !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL arst_setup got rf_ld=%0b stall=%0b want 1/1", bus.rf_ld, bus.rd_stall);
    end
    #1;
    rst_n = 1'b0;
    #1;
    nCompared++;
    if (bus.rf_ld !== 1'b0 || bus.rf_addr !== 5'd0 || bus.rf_data !== 32'd0 || bus.rd_stall !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL arst_clear got ld=%0b addr=%0d data=%h stall=%0b want 0/0/0/0",
               bus.rf_ld, bus.rf_addr, bus.rf_data, bus.rd_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd1;
    bus.ld_valid  = 1'b1;
    bus.ld_addr   = 5'd2;
    #1;
    nCompared++;
    if (bus.alu_ready !== 1'b1 || bus.ld_ready !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL arst_grant got alu=%0b ld=%0b want 1/0", bus.alu_ready, bus.ld_ready);
    end
    idleInputs();
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    test_reset();
    test_contention();
    test_single_alu();
    test_g0();
    test_scoreboard();
    test_same_edge();
    test_async_reset();
    nextCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
